// File: rtl/frame_ram_ctrl.sv
// frame_ram_ctrl: simple-dual-port frame RAM with a registered read pipeline
// (1 or 2 cycles) and a fill engine that sweeps the whole array with one value.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   wr_en/addr/data     external write port, accepted only while wr_ready
//   wr_ready            ~fill_busy; external writes are dropped during a sweep
//   rd_en/addr          read request, accepted every cycle
//   rd_data/rd_valid    read result READ_LATENCY cycles after rd_en; rd_data
//                       holds its last value between reads
//   fill_start/value    start a sweep; value sampled on the start cycle
//   fill_busy           high for exactly DEPTH cycles while the sweep writes
//   fill_done           one-cycle pulse in the cycle after the last busy cycle
module frame_ram_ctrl #(
  parameter  int WORD_WIDTH   = 12,
  parameter  int DEPTH        = 19200,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_W       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  fill_start,
  input  logic [WORD_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("frame_ram_ctrl: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("frame_ram_ctrl: DEPTH must be at least 2");
  end

  // One extra bit so the range compare is exact for power-of-two DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------- fill FSM
  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_st_e;

  fill_st_e              st_q, st_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [WORD_WIDTH-1:0] val_q, val_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      ptr_q <= '0;
      val_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      val_q <= val_d;
    end
  end

  // The terminal compare happens on DEPTH-1 itself, so the pointer never
  // has to represent DEPTH and cannot wrap.
  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
    val_d = val_q;
    unique case (st_q)
      IDLE: if (fill_start) begin
        st_d  = FILL;
        ptr_d = '0;
        val_d = fill_value;
      end
      FILL: if (ptr_q == LAST_PTR) st_d = DONE;
            else                   ptr_d = ptr_q + 1'b1;
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign fill_busy = (st_q == FILL);
  assign fill_done = (st_q == DONE);
  assign wr_ready  = ~fill_busy;

  // ------------------------------------------------------------------ array
  // No reset on the array: contents survive rst_n, including a partial sweep.
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_hit, rd_hit, mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  assign wr_hit    = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_hit    = ({1'b0, rd_addr} < DEPTH_X);
  assign mem_we    = fill_busy | (wr_en & wr_hit);
  assign mem_waddr = fill_busy ? ptr_q : wr_addr;
  assign mem_wdata = fill_busy ? val_q : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------- read pipeline
  // Stage 1 samples the array in the same edge as a write, so a colliding
  // read gets the pre-write word. Later stages only advance on a valid word,
  // which keeps rd_data stable between reads.
  logic [READ_LATENCY:1]                 vld_pipe_q;
  logic [READ_LATENCY:1][WORD_WIDTH-1:0] dat_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= rd_en;
      if (rd_en) dat_pipe_q[1] <= rd_hit ? mem_q[rd_addr] : '0;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe_q[READ_LATENCY];
  assign rd_data  = dat_pipe_q[READ_LATENCY];

endmodule

// File: tb/tb_frame_ram_ctrl.sv
// Bench for frame_ram_ctrl. Group A drives two DEPTH=16 instances (latency 1
// and 2) with identical stimulus; group B drives a DEPTH=10 instance. A
// reference model of the array and fill FSM predicts reads (queued per
// instance) and the per-cycle busy/done/ready flags.
module tb_frame_ram_ctrl;
  localparam int W = 12, DA = 16, DB = 10;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // group A inputs / outputs
  logic         a_wr_en, a_rd_en, a_fill_start;
  logic [3:0]   a_wr_addr, a_rd_addr;
  logic [W-1:0] a_wr_data, a_fill_value;
  logic         a1_wr_ready, a1_rd_valid, a1_fill_busy, a1_fill_done;
  logic         a2_wr_ready, a2_rd_valid, a2_fill_busy, a2_fill_done;
  logic [W-1:0] a1_rd_data, a2_rd_data;
  // group B
  logic         b_wr_en, b_rd_en, b_fill_start;
  logic [3:0]   b_wr_addr, b_rd_addr;
  logic [W-1:0] b_wr_data, b_fill_value;
  logic         b_wr_ready, b_rd_valid, b_fill_busy, b_fill_done;
  logic [W-1:0] b_rd_data;

  frame_ram_ctrl #(.WORD_WIDTH(W), .DEPTH(DA), .READ_LATENCY(1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_ready(a1_wr_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a1_rd_data),
    .rd_valid(a1_rd_valid), .fill_start(a_fill_start), .fill_value(a_fill_value),
    .fill_busy(a1_fill_busy), .fill_done(a1_fill_done));

  frame_ram_ctrl #(.WORD_WIDTH(W), .DEPTH(DA), .READ_LATENCY(2)) u_a2 (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_ready(a2_wr_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a2_rd_data),
    .rd_valid(a2_rd_valid), .fill_start(a_fill_start), .fill_value(a_fill_value),
    .fill_busy(a2_fill_busy), .fill_done(a2_fill_done));

  frame_ram_ctrl #(.WORD_WIDTH(W), .DEPTH(DB), .READ_LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_ready(b_wr_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .fill_start(b_fill_start), .fill_value(b_fill_value),
    .fill_busy(b_fill_busy), .fill_done(b_fill_done));

  // reference model
  logic [W-1:0] ma [DA];
  logic [W-1:0] mb [DB];
  int           a_st, a_ptr, b_st, b_ptr;   // 0 idle, 1 fill, 2 done
  logic [W-1:0] a_val, b_val;
  exp_t         sbq [3][$];
  logic [W-1:0] last [3];
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_wr_en = 0; a_rd_en = 0; a_fill_start = 0;
    b_wr_en = 0; b_rd_en = 0; b_fill_start = 0;
  endtask

  // One clock: predict reads from pre-edge contents, apply writes and FSM
  // transitions to the model, cross the edge, then check the fill flags.
  task automatic step();
    exp_t e;
    if (a_rd_en) begin
      e.data = ma[a_rd_addr];
      e.due = cyc + 1; sbq[0].push_back(e);
      e.due = cyc + 2; sbq[1].push_back(e);
    end
    if (b_rd_en) begin
      e.data = (int'(b_rd_addr) < DB) ? mb[b_rd_addr] : '0;
      e.due = cyc + 1; sbq[2].push_back(e);
    end
    if (a_st == 1) ma[a_ptr] = a_val;
    else if (a_wr_en) ma[a_wr_addr] = a_wr_data;
    if (b_st == 1) mb[b_ptr] = b_val;
    else if (b_wr_en && int'(b_wr_addr) < DB) mb[b_wr_addr] = b_wr_data;
    case (a_st)
      0: if (a_fill_start) begin a_st = 1; a_ptr = 0; a_val = a_fill_value; end
      1: if (a_ptr == DA-1) a_st = 2; else a_ptr++;
      default: a_st = 0;
    endcase
    case (b_st)
      0: if (b_fill_start) begin b_st = 1; b_ptr = 0; b_val = b_fill_value; end
      1: if (b_ptr == DB-1) b_st = 2; else b_ptr++;
      default: b_st = 0;
    endcase
    @(posedge clk); #1;
    chk("a1_busy",  a1_fill_busy, a_st == 1);
    chk("a1_done",  a1_fill_done, a_st == 2);
    chk("a1_ready", a1_wr_ready,  a_st != 1);
    chk("a2_busy",  a2_fill_busy, a_st == 1);
    chk("a2_done",  a2_fill_done, a_st == 2);
    chk("b_busy",   b_fill_busy,  b_st == 1);
    chk("b_done",   b_fill_done,  b_st == 2);
    chk("b_ready",  b_wr_ready,   b_st != 1);
  endtask

  // Read monitor: every rd_valid pulse must match the oldest pending
  // expectation in both data and cycle; rd_data must hold otherwise.
  task automatic mon(input int id, input logic v, input logic [W-1:0] d);
    exp_t e;
    if (v) begin
      n_assert++;
      assert (sbq[id].size() > 0) else begin
        n_fail++;
        $error("FAIL rd%0d_spurious: observed valid with data %h expected no pulse", id, d);
      end
      if (sbq[id].size() > 0) begin
        e = sbq[id].pop_front();
        chk($sformatf("rd%0d_data", id), d, e.data);
        n_assert++;
        assert (cyc == e.due) else begin
          n_fail++;
          $error("FAIL rd%0d_latency: observed cycle %0d expected cycle %0d", id, cyc, e.due);
        end
      end
      last[id] = d;
    end else begin
      chk($sformatf("rd%0d_hold", id), d, last[id]);
      if (sbq[id].size() > 0) begin
        n_assert++;
        assert (sbq[id][0].due > cyc) else begin
          n_fail++;
          $error("FAIL rd%0d_missing: observed no pulse at cycle %0d expected data %h",
                 id, cyc, sbq[id][0].data);
          void'(sbq[id].pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, a1_rd_valid, a1_rd_data);
      mon(1, a2_rd_valid, a2_rd_data);
      mon(2, b_rd_valid,  b_rd_data);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a1_vld"},  a1_rd_valid, 1'b0);
    chk({tag, "_a1_data"}, a1_rd_data,  '0);
    chk({tag, "_a2_vld"},  a2_rd_valid, 1'b0);
    chk({tag, "_a2_data"}, a2_rd_data,  '0);
    chk({tag, "_b_vld"},   b_rd_valid,  1'b0);
    chk({tag, "_a1_busy"}, a1_fill_busy, 1'b0);
    chk({tag, "_a1_done"}, a1_fill_done, 1'b0);
    chk({tag, "_a1_rdy"},  a1_wr_ready,  1'b1);
    chk({tag, "_a2_busy"}, a2_fill_busy, 1'b0);
    chk({tag, "_b_busy"},  b_fill_busy,  1'b0);
    chk({tag, "_b_rdy"},   b_wr_ready,   1'b1);
  endtask

  initial begin
    idle_inputs();
    a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0; a_fill_value = '0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0; b_fill_value = '0;
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
    a_st = 0; a_ptr = 0; b_st = 0; b_ptr = 0; a_val = '0; b_val = '0;
    foreach (last[i]) last[i] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst");
    rst_n = 1;

    // sweep both arrays to zero so contents are known; checks fill timing
    a_fill_start = 1; a_fill_value = '0; b_fill_start = 1; b_fill_value = '0;
    step(); idle_inputs();
    repeat (20) step();

    // write ABC @5, read it back the next cycle (latency 1 and 2)
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 12'hABC;
    step(); idle_inputs();
    a_rd_en = 1; a_rd_addr = 5;
    step(); idle_inputs();
    repeat (3) step();

    // same-edge write/read at 7 returns old data, next cycle the new data
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 12'h123; a_rd_en = 1; a_rd_addr = 7;
    step(); idle_inputs();
    a_rd_en = 1; a_rd_addr = 7;
    step(); idle_inputs();

    // distinct patterns, then back-to-back reads of the whole array
    for (int k = 0; k < 16; k++) begin
      a_wr_en = 1; a_wr_addr = 4'(k); a_wr_data = 12'(k * 12'h111 + 12'h00F);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      a_rd_en = 1; a_rd_addr = 4'(15 - k);
      step();
    end
    idle_inputs();

    // DEPTH=10: writes beyond the array are dropped, reads beyond return 0
    for (int k = 0; k < 10; k++) begin
      b_wr_en = 1; b_wr_addr = 4'(k); b_wr_data = 12'(12'h100 + k);
      step();
    end
    b_wr_addr = 12; b_wr_data = 12'hFFF; step();
    b_wr_addr = 10; b_wr_data = 12'hEEE; step();
    idle_inputs();
    b_rd_en = 1; b_rd_addr = 12; step();
    for (int k = 0; k < 10; k++) begin
      b_rd_addr = 4'(k); step();
    end
    idle_inputs();
    repeat (3) step();

    // fill F0F with a concurrent accepted write on the start cycle, a dropped
    // write mid-sweep, ignored re-starts, and a read every cycle
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      a_rd_en = 1; a_rd_addr = 4'(k);
      if (k == 0) begin
        a_fill_start = 1; a_fill_value = 12'hF0F;
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 12'h777; a_rd_addr = 3;
      end
      if (k == 1) a_rd_addr = 3;
      if (k == 3) begin a_wr_en = 1; a_wr_addr = 3; a_wr_data = 12'h555; end
      if (k >= 5 && k <= 8) begin a_fill_start = 1; a_fill_value = 12'h111; end
      step();
    end
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      a_rd_en = 1; a_rd_addr = 4'(k); step();
    end
    idle_inputs();
    repeat (4) step();

    // reset with the fill pointer at 6: sweep aborts, no done pulse
    a_fill_start = 1; a_fill_value = 12'h0AA;
    step(); idle_inputs();
    for (int g = 0; g < 20 && !(a_st == 1 && a_ptr == 6); g++) step();
    #2 rst_n = 0;
    #1 chk_reset_outputs("abort");
    a_st = 0; b_st = 0;
    foreach (last[i]) last[i] = '0;
    @(posedge clk); #1 rst_n = 1;
    repeat (2) step();
    for (int k = 0; k < 16; k++) begin
      a_rd_en = 1; a_rd_addr = 4'(k); step();
    end
    idle_inputs();
    repeat (4) step();

    for (int i = 0; i < 3; i++) chk($sformatf("q%0d_empty", i), 12'(sbq[i].size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
